flag_gen_serial: RTL

Multi-cycle compare engine that produces the Zero/Overflow/Negative/CarryOut flag set consumed by the branch condition logic. It computes src_a - src_b as src_a + ~src_b + 1, processing CHUNK bits per cycle, for the area-reduced multicycle datapath. Flag semantics match the branch decoder exactly: CarryOut=1 means no borrow (src_a >= src_b unsigned).

---
 rtl/flag_gen_serial_pkg.sv | 16 +
 rtl/flag_gen_serial_chunk_adder.sv | 19 +
 rtl/flag_gen_serial.sv | 139 +++++++++++++
 3 files changed

// File: rtl/flag_gen_serial_pkg.sv
// Shared encodings for the serial compare engine and the branch decoder.
// Flag index constants select bits of the packed Z/V/N/C flag vector.
package flag_gen_serial_pkg;

  typedef enum logic [1:0] {
    FG_IDLE = 2'd0,
    FG_RUN  = 2'd1,
    FG_DONE = 2'd2
  } fg_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 3;

endpackage

// File: rtl/flag_gen_serial_chunk_adder.sv
// Combinational W-bit adder slice with carry in/out.
// One slice is reused every RUN cycle by the serial compare engine.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/flag_gen_serial.sv
// Multicycle a - b compare engine producing Z/V/N/C branch flags.
// Processes CHUNK bits per RUN cycle through one shared adder slice.
module flag_gen_serial
  import flag_gen_serial_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            Zero,
  output logic            Overflow,
  output logic            Negative,
  output logic            CarryOut
);

  localparam int N  = XLEN / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (XLEN % CHUNK != 0) begin : g_chunk_chk
    $error("XLEN must be a multiple of CHUNK");
  end

  fg_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            zacc_q, zacc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [3:0]      flags_q, flags_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  int              base;
  logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
  logic            ch_cout;
  logic            last;

  assign base = int'(cnt_q) * CHUNK;
  assign ch_a = a_q[base +: CHUNK];
  assign ch_b = ~b_q[base +: CHUNK];
  assign last = (cnt_q == CW'(N - 1));

  chunk_adder #(.W(CHUNK)) u_add (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      FG_IDLE, FG_DONE: begin
        if (start) begin
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = '0;
          carry_d = 1'b1;
          zacc_d  = 1'b1;
          state_d = FG_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = FG_IDLE;
        end
      end
      FG_RUN: begin
        result_d[base +: CHUNK] = ch_sum;
        carry_d = ch_cout;
        zacc_d  = zacc_q & ~(|ch_sum);
        if (last) begin
          state_d         = FG_DONE;
          done_d          = 1'b1;
          flags_d[FLAG_Z] = zacc_d;
          flags_d[FLAG_N] = result_d[XLEN-1];
          flags_d[FLAG_C] = ch_cout;
          flags_d[FLAG_V] = (a_q[XLEN-1] ^ b_q[XLEN-1])
                          & (result_d[XLEN-1] ^ a_q[XLEN-1]);
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = FG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FG_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      zacc_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign Zero     = flags_q[FLAG_Z];
  assign Overflow = flags_q[FLAG_V];
  assign Negative = flags_q[FLAG_N];
  assign CarryOut = flags_q[FLAG_C];

endmodule
